// File: rtl/score_disp_pkg.sv
// Shared types and constants for the score display driver:
// FSM state encoding, active-low gfedcba segment patterns and the shift count.
`default_nettype none

package score_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam int SHIFT_CYCLES = 16;

endpackage : score_disp_pkg

`default_nettype wire

// File: rtl/seven_seg_decoder.sv
// Combinational BCD digit to active-low 7-segment pattern {g,f,e,d,c,b,a}.
// Non-decimal codes and an asserted blank both produce a dark digit.
`default_nettype none

module seven_seg_decoder
  import score_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule : seven_seg_decoder

`default_nettype wire

// File: rtl/score_display_driver.sv
// Sequential double-dabble binary-to-BCD converter driving five registered
// active-low 7-segment displays, restarting whenever the score changes.
`default_nettype none

module score_display_driver
  import score_disp_pkg::*;
#(
  parameter int NUM_DIGITS    = 5,
  parameter int SCORE_W       = 16,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SCORE_W-1:0]      score,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [6:0]              hex0,
  output logic [6:0]              hex1,
  output logic [6:0]              hex2,
  output logic [6:0]              hex3,
  output logic [6:0]              hex4,
  output logic                    busy,
  output logic                    valid
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(SHIFT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SHIFT_CYCLES - 1);
  localparam logic [6:0] UPPER_RST = (BLANK_LEADING != 0) ? SEG_BLANK : SEG_0;

  state_t             state;
  state_t             next_state;
  logic [SCORE_W-1:0] last_score;
  logic [SCORE_W-1:0] shift_reg;
  logic [BCD_W-1:0]   bcd_work;
  logic [BCD_W-1:0]   adj;
  logic [CNT_W-1:0]   bit_cnt;
  logic [BCD_W-1:0]   bcd_r;
  logic               valid_r;
  logic [NUM_DIGITS-1:0] blank;
  logic [6:0]         seg_dec [NUM_DIGITS];
  logic [6:0]         hex_r   [NUM_DIGITS];

  // Per-nibble add-3 correction; carries never cross a digit boundary.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    assign adj[4*k +: 4] = (bcd_work[4*k +: 4] >= 4'd5) ? (bcd_work[4*k +: 4] + 4'd3)
                                                        : bcd_work[4*k +: 4];
    if (k == 0) begin : g_units
      assign blank[k] = 1'b0;
    end else begin : g_upper
      assign blank[k] = (BLANK_LEADING != 0) && (bcd_work[BCD_W-1:4*k] == '0);
    end

    seven_seg_decoder u_dec (
      .digit (bcd_work[4*k +: 4]),
      .blank (blank[k]),
      .seg   (seg_dec[k])
    );
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (score != last_score) next_state = LOAD;
      LOAD:    next_state = SHIFT;
      SHIFT:   if (bit_cnt == LAST_CNT) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_score <= '0;
      shift_reg  <= '0;
      bcd_work   <= '0;
      bit_cnt    <= '0;
      bcd_r      <= '0;
      valid_r    <= 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        hex_r[k] <= (k == 0) ? SEG_0 : UPPER_RST;
      end
    end else begin
      state   <= next_state;
      valid_r <= (state == DONE);
      case (state)
        LOAD: begin
          last_score <= score;
          shift_reg  <= score;
          bcd_work   <= '0;
          bit_cnt    <= '0;
        end
        SHIFT: begin
          {bcd_work, shift_reg} <= {adj, shift_reg} << 1;
          bit_cnt               <= bit_cnt + 1'b1;
        end
        DONE: begin
          bcd_r <= bcd_work;
          for (int k = 0; k < NUM_DIGITS; k++) begin
            hex_r[k] <= seg_dec[k];
          end
        end
        default: ;
      endcase
    end
  end

  assign bcd   = bcd_r;
  assign valid = valid_r;
  assign busy  = (state != IDLE);
  assign hex0  = hex_r[0];
  assign hex1  = hex_r[1];
  assign hex2  = hex_r[2];
  assign hex3  = hex_r[3];
  assign hex4  = hex_r[4];

endmodule : score_display_driver

`default_nettype wire

// File: tb/tb_score_display_driver.sv
// Directed and randomized checks of score_display_driver against a decimal
// arithmetic reference model, with both blanking configurations side by side.
`default_nettype none

module tb_score_display_driver;

  logic        clk;
  logic        rst_n;
  logic [15:0] score;
  logic [19:0] bcd_b, bcd_n;
  logic [6:0]  hx  [5];
  logic [6:0]  hxn [5];
  logic        busy_b, valid_b, busy_n, valid_n;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] SEG_TAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                          7'b0000000, 7'b0010000};
  localparam int P10 [5] = '{1, 10, 100, 1000, 10000};

  score_display_driver #(.NUM_DIGITS(5), .SCORE_W(16), .BLANK_LEADING(1)) dut (
    .clk(clk), .rst_n(rst_n), .score(score), .bcd(bcd_b),
    .hex0(hx[0]), .hex1(hx[1]), .hex2(hx[2]), .hex3(hx[3]), .hex4(hx[4]),
    .busy(busy_b), .valid(valid_b)
  );

  score_display_driver #(.NUM_DIGITS(5), .SCORE_W(16), .BLANK_LEADING(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .score(score), .bcd(bcd_n),
    .hex0(hxn[0]), .hex1(hxn[1]), .hex2(hxn[2]), .hex3(hxn[3]), .hex4(hxn[4]),
    .busy(busy_n), .valid(valid_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] ref_bcd(int v);
    logic [19:0] r = '0;
    for (int k = 0; k < 5; k++) r[4*k +: 4] = 4'((v / P10[k]) % 10);
    return r;
  endfunction

  function automatic logic [6:0] ref_hex(int v, int k, bit blank_lead);
    if (blank_lead && k > 0 && v < P10[k]) return 7'b1111111;
    return SEG_TAB[(v / P10[k]) % 10];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(string tag);
    chk({tag, "_bcd"}, 32'(bcd_b), 32'h0);
    chk({tag, "_busy"}, 32'(busy_b), 32'h0);
    chk({tag, "_valid"}, 32'(valid_b), 32'h0);
    chk({tag, "_hex0"}, 32'(hx[0]), 32'(7'b1000000));
    for (int k = 1; k < 5; k++) chk($sformatf("%s_hex%0d", tag, k), 32'(hx[k]), 32'(7'b1111111));
    for (int k = 0; k < 5; k++) chk($sformatf("%s_nb_hex%0d", tag, k), 32'(hxn[k]), 32'(7'b1000000));
  endtask

  // Starts at the edge that samples the new score; lat counts edges to valid.
  task automatic run_conv(int change_at, int change_val, output int lat, output bit busy_ok);
    @(posedge clk); #1;
    lat = 0;
    busy_ok = 1'b1;
    while (!valid_b && lat < 40) begin
      busy_ok &= busy_b;
      @(posedge clk); #1;
      lat++;
      if (lat == change_at) score = 16'(change_val);
    end
  endtask

  task automatic conv_check(int v, bit drive, int change_at, int change_val);
    int lat;
    bit busy_ok;
    if (drive) score = 16'(v);
    run_conv(change_at, change_val, lat, busy_ok);
    chk($sformatf("lat_%0d", v), 32'(lat), 32'd18);
    chk($sformatf("busy_during_%0d", v), 32'(busy_ok), 32'd1);
    chk($sformatf("busy_after_%0d", v), 32'(busy_b), 32'd0);
    chk($sformatf("bcd_%0d", v), 32'(bcd_b), 32'(ref_bcd(v)));
    chk($sformatf("bcd_nb_%0d", v), 32'(bcd_n), 32'(ref_bcd(v)));
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hex%0d_%0d", k, v), 32'(hx[k]), 32'(ref_hex(v, k, 1'b1)));
      chk($sformatf("nb_hex%0d_%0d", k, v), 32'(hxn[k]), 32'(ref_hex(v, k, 1'b0)));
    end
  endtask

  initial begin
    int quiet;
    int prev;
    int v;
    rst_n = 1'b0;
    score = 16'd1234;
    repeat (3) @(posedge clk);
    #1 check_reset("rst");

    @(negedge clk) rst_n = 1'b1;
    conv_check(1234, 1'b0, -1, 0);
    conv_check(0, 1'b1, -1, 0);
    conv_check(20, 1'b1, -1, 0);
    chk("lit_bcd_20", 32'(bcd_b), 32'h00020);
    chk("lit_hex1_20", 32'(hx[1]), 32'(7'b0100100));
    chk("lit_hex2_20", 32'(hx[2]), 32'(7'b1111111));
    conv_check(65535, 1'b1, -1, 0);
    chk("lit_hex4_max", 32'(hx[4]), 32'(7'b0000010));
    chk("lit_hex0_max", 32'(hx[0]), 32'(7'b0010010));

    quiet = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (valid_b || busy_b) quiet++;
    end
    chk("idle_quiet", 32'(quiet), 32'd0);

    // Change arrives four cycles into SHIFT; the captured value finishes first.
    conv_check(20, 1'b1, 5, 70);
    conv_check(70, 1'b0, -1, 0);

    score = 16'd500;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset("midrst");
    @(negedge clk) rst_n = 1'b1;
    conv_check(500, 1'b0, -1, 0);

    conv_check(100, 1'b1, -1, 0);
    chk("lit_nb_hex2_100", 32'(hxn[2]), 32'(7'b1111001));
    chk("lit_nb_hex4_100", 32'(hxn[4]), 32'(7'b1000000));

    prev = 100;
    for (int i = 0; i < 10; i++) begin
      v = int'($urandom_range(1, 65535));
      if (v == prev) v = v ^ 1;
      conv_check(v, 1'b1, -1, 0);
      prev = v;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_score_display_driver

`default_nettype wire
